// File: rtl/rice_decode_ctrl.sv
// Rice block decoder control FSM: sequences window loads, header/FS/split shifts and refills.
// Optional error counter output enabled by defining RICE_DECODE_CTRL_ERRCNT_EN.
module rice_decode_ctrl #(
    parameter int J_MAX = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cfg_j,
    input  logic [7:0]  cfg_nblk,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [5:0]  fs_len,
    output logic        ldor,
    output logic [31:0] ld_data,
    output logic        refill,
    output logic [6:0]  refill_pos,
    output logic        shift_en,
    output logic [5:0]  shift_amt,
    output logic        phase,
    output logic [3:0]  k_out,
    output logic        blk_done,
    output logic        pkt_done,
    output logic        busy,
    output logic        err
`ifdef RICE_DECODE_CTRL_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [2:0] {
        IDLE, LOAD0, LOAD1, HDR, FS, SPLIT, NEXT, ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [6:0]  avail_reg, avail_next;
    logic [5:0]  samp_cnt_reg, samp_cnt_next;
    logic [7:0]  blk_cnt_reg, blk_cnt_next;
    logic [3:0]  k_reg, k_next;
    logic [5:0]  j_reg, j_next;
    logic        err_reg, err_next;
    // Shadow of the datapath window; only the top nibble is needed (header ID).
    logic [63:0] win_reg, win_next;

    logic [5:0]  j_eff;
    logic [7:0]  nblk_eff;
    logic [6:0]  consumed;
    logic [6:0]  remain;

    // The load word is the data path itself, so it is passed straight through.
    assign ld_data = in_data;
    assign err     = err_reg;

    always_comb begin
        j_eff    = cfg_j;
        if (cfg_j == 6'd0) begin
            j_eff = 6'd1;
        end else if (32'(cfg_j) > J_MAX) begin
            j_eff = 6'(J_MAX);
        end
        nblk_eff = (cfg_nblk == 8'd0) ? 8'd1 : cfg_nblk;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            avail_reg    <= 7'd0;
            samp_cnt_reg <= 6'd0;
            blk_cnt_reg  <= 8'd0;
            k_reg        <= 4'd0;
            j_reg        <= 6'd0;
            err_reg      <= 1'b0;
            win_reg      <= 64'd0;
        end else begin
            state_reg    <= state_next;
            avail_reg    <= avail_next;
            samp_cnt_reg <= samp_cnt_next;
            blk_cnt_reg  <= blk_cnt_next;
            k_reg        <= k_next;
            j_reg        <= j_next;
            err_reg      <= err_next;
            win_reg      <= win_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        avail_next    = avail_reg;
        samp_cnt_next = samp_cnt_reg;
        blk_cnt_next  = blk_cnt_reg;
        k_next        = k_reg;
        j_next        = j_reg;
        err_next      = err_reg;
        win_next      = win_reg;
        in_ready      = 1'b0;
        ldor          = 1'b0;
        refill        = 1'b0;
        refill_pos    = 7'd0;
        shift_en      = 1'b0;
        shift_amt     = 6'd0;
        phase         = 1'b0;
        k_out         = k_reg;
        blk_done      = 1'b0;
        pkt_done      = 1'b0;
        busy          = 1'b0;
        consumed      = 7'd0;
        remain        = avail_reg;

        unique case (state_reg)
            IDLE, ERR: begin
                if (start) begin
                    state_next   = LOAD0;
                    avail_next   = 7'd0;
                    samp_cnt_next = 6'd0;
                    j_next       = j_eff;
                    blk_cnt_next = nblk_eff;
                    err_next     = 1'b0;
                end
            end
            LOAD0: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    ldor       = 1'b1;
                    avail_next = 7'd32;
                    state_next = LOAD1;
                end
            end
            LOAD1: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    ldor       = 1'b1;
                    avail_next = 7'd64;
                    state_next = HDR;
                end
            end
            HDR: begin
                busy  = 1'b1;
                k_out = win_reg[63:60];
                if (avail_reg >= 7'd4) begin
                    if (win_reg[63:60] == 4'hF) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end else begin
                        shift_en      = 1'b1;
                        shift_amt     = 6'd4;
                        k_next        = win_reg[63:60];
                        samp_cnt_next = j_reg;
                        state_next    = FS;
                    end
                end
            end
            FS: begin
                busy = 1'b1;
                if (fs_len != 6'd0 && {1'b0, fs_len} <= avail_reg) begin
                    shift_en  = 1'b1;
                    shift_amt = fs_len;
                    if (samp_cnt_reg == 6'd1) begin
                        samp_cnt_next = j_reg;
                        // k=0 blocks carry no split bits, so the block ends here.
                        if (k_reg == 4'd0) begin
                            blk_done   = 1'b1;
                            state_next = NEXT;
                        end else begin
                            state_next = SPLIT;
                        end
                    end else begin
                        samp_cnt_next = samp_cnt_reg - 6'd1;
                    end
                end else if (fs_len == 6'd0 && avail_reg == 7'd64) begin
                    state_next = ERR;
                    err_next   = 1'b1;
                end
            end
            SPLIT: begin
                busy  = 1'b1;
                phase = 1'b1;
                if ({3'b000, k_reg} <= avail_reg) begin
                    shift_en  = 1'b1;
                    shift_amt = {2'b00, k_reg};
                    if (samp_cnt_reg == 6'd1) begin
                        blk_done   = 1'b1;
                        state_next = NEXT;
                    end else begin
                        samp_cnt_next = samp_cnt_reg - 6'd1;
                    end
                end
            end
            NEXT: begin
                busy = 1'b1;
                if (blk_cnt_reg > 8'd1) begin
                    blk_cnt_next = blk_cnt_reg - 8'd1;
                    state_next   = HDR;
                end else begin
                    blk_cnt_next = 8'd0;
                    pkt_done     = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Refill decision uses the bits left after this cycle's shift.
        if (state_reg == HDR || state_reg == FS || state_reg == SPLIT) begin
            consumed = shift_en ? {1'b0, shift_amt} : 7'd0;
            remain   = avail_reg - consumed;
            in_ready = (remain <= 7'd32);
            if (in_ready && in_valid) begin
                refill     = 1'b1;
                refill_pos = 7'd32 - remain;
                avail_next = remain + 7'd32;
            end else begin
                avail_next = remain;
            end
        end

        if (ldor) begin
            win_next = {win_reg[31:0], in_data};
        end else begin
            win_next = shift_en ? (win_reg << shift_amt) : win_reg;
            if (refill) begin
                win_next = win_next | ({32'd0, in_data} << refill_pos);
            end
        end
    end

`ifdef RICE_DECODE_CTRL_ERRCNT_EN
    logic [15:0] err_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_reg <= 16'd0;
        end else if (state_next == ERR && state_reg != ERR && err_count_reg != 16'hFFFF) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end

    assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_rice_decode_ctrl.sv
// Self-checking bench for rice_decode_ctrl: builds Rice bitstreams, models the window
// datapath, and predicts every shift, refill and done pulse from the bitstream itself.
module tb_rice_decode_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  cfg_j;
    logic [7:0]  cfg_nblk;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  fs_len;
    logic        ldor;
    logic [31:0] ld_data;
    logic        refill;
    logic [6:0]  refill_pos;
    logic        shift_en;
    logic [5:0]  shift_amt;
    logic        phase;
    logic [3:0]  k_out;
    logic        blk_done;
    logic        pkt_done;
    logic        busy;
    logic        err;
`ifdef RICE_DECODE_CTRL_ERRCNT_EN
    logic [15:0] err_count;
`endif

    rice_decode_ctrl #(.J_MAX(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_j      (cfg_j),
        .cfg_nblk   (cfg_nblk),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .fs_len     (fs_len),
        .ldor       (ldor),
        .ld_data    (ld_data),
        .refill     (refill),
        .refill_pos (refill_pos),
        .shift_en   (shift_en),
        .shift_amt  (shift_amt),
        .phase      (phase),
        .k_out      (k_out),
        .blk_done   (blk_done),
        .pkt_done   (pkt_done),
        .busy       (busy),
        .err        (err)
`ifdef RICE_DECODE_CTRL_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Window datapath model: load, shift, OR-in refill, and leading-one length.
    logic [63:0] win;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            win <= 64'd0;
        end else if (ldor) begin
            win <= {win[31:0], ld_data};
        end else begin
            win <= (shift_en ? (win << shift_amt) : win)
                 | (refill ? ({32'd0, in_data} << refill_pos) : 64'd0);
        end
    end

    always_comb begin
        fs_len = 6'd0;
        for (int i = 62; i >= 0; i--) begin
            if (win[63 - i]) fs_len = 6'(i + 1);
        end
    end

    typedef struct {
        int amt;
        int ph;
        int k;
        bit last_blk;
        bit last_pkt;
        bit err;
    } exp_t;

    exp_t        exp_q[$];
    bit          bits_q[$];
    logic [31:0] word_q[$];
    int          cur_k;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push_bits(input int v, input int n);
        for (int i = n - 1; i >= 0; i--) bits_q.push_back(bit'((v >> i) & 1));
    endtask

    task automatic add_hdr(input int id);
        exp_t e;
        push_bits(id, 4);
        if (id == 15) e = '{amt:0, ph:0, k:0, last_blk:0, last_pkt:0, err:1};
        else          e = '{amt:4, ph:0, k:id, last_blk:0, last_pkt:0, err:0};
        cur_k = id;
        exp_q.push_back(e);
    endtask

    task automatic add_fs(input int q);
        exp_t e;
        push_bits(1, q + 1);
        e = '{amt:q + 1, ph:0, k:cur_k, last_blk:0, last_pkt:0, err:0};
        exp_q.push_back(e);
    endtask

    task automatic add_split(input int r);
        exp_t e;
        push_bits(r, cur_k);
        e = '{amt:cur_k, ph:1, k:cur_k, last_blk:0, last_pkt:0, err:0};
        exp_q.push_back(e);
    endtask

    task automatic add_err_marker();
        exp_t e;
        e = '{amt:0, ph:0, k:0, last_blk:0, last_pkt:0, err:1};
        exp_q.push_back(e);
    endtask

    task automatic mark_last(input bit pkt);
        exp_t e;
        e = exp_q.pop_back();
        e.last_blk = 1'b1;
        e.last_pkt = pkt;
        exp_q.push_back(e);
    endtask

    task automatic add_block(input int id, input int j, input bit ones);
        add_hdr(id);
        for (int s = 0; s < j; s++) add_fs(ones ? 0 : int'($urandom_range(0, 5)));
        if (id != 0) begin
            for (int s = 0; s < j; s++) add_split(int'($urandom_range(0, (1 << id) - 1)));
        end
    endtask

    task automatic new_pkt();
        exp_q.delete();
        bits_q.delete();
        word_q.delete();
    endtask

    task automatic pack_words();
        logic [31:0] w;
        while (bits_q.size() > 0) begin
            w = 32'd0;
            for (int i = 0; i < 32; i++) begin
                w = {w[30:0], (bits_q.size() > 0) ? bits_q.pop_front() : 1'b0};
            end
            word_q.push_back(w);
        end
    endtask

    // vmode: 0 random valid, 1 always valid, 2 valid withheld until three stalls seen
    task automatic run_pkt(input string tag, input int j, input int nblk, input int vmode,
                           input int exp_cycles, input bit abort_split);
        int   loads, avail_m, cyc, stall_cnt, cons;
        bit   done, in_next, next_pkt, fire, exp_sh, exp_rdy, abort_now;
        exp_t e;
        cfg_j    = 6'(j);
        cfg_nblk = 8'(nblk);
        start    = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        loads     = 0;
        avail_m   = 0;
        cyc       = 0;
        stall_cnt = 0;
        done      = 1'b0;
        in_next   = 1'b0;
        next_pkt  = 1'b0;
        while (!done) begin
            cyc++;
            abort_now = 1'b0;
            case (vmode)
                0:       in_valid = ($urandom_range(0, 3) != 0);
                1:       in_valid = 1'b1;
                default: in_valid = (loads < 2) || (stall_cnt >= 3);
            endcase
            in_data = (word_q.size() > 0) ? word_q[0] : 32'd0;
            @(negedge clk);
            fire = in_valid && in_ready;
            if (cyc > 3000) begin
                chk({tag, "_timeout"}, cyc, 0);
                done = 1'b1;
            end else if (loads < 2) begin
                chk({tag, "_busy_ld"}, busy, 1);
                chk({tag, "_ready_ld"}, in_ready, 1);
                chk({tag, "_ldor"}, ldor, in_valid);
                chk({tag, "_shift_ld"}, shift_en, 0);
                chk({tag, "_err_ld"}, err, 0);
                if (in_valid) begin
                    loads++;
                    avail_m += 32;
                end
            end else if (in_next) begin
                chk({tag, "_next_shift"}, shift_en, 0);
                chk({tag, "_next_ready"}, in_ready, 0);
                chk({tag, "_next_busy"}, busy, 1);
                chk({tag, "_pkt_done"}, pkt_done, next_pkt);
                in_next = 1'b0;
                if (next_pkt) begin
                    done = 1'b1;
                    if (exp_cycles > 0) chk({tag, "_latency"}, cyc, exp_cycles);
                end
            end else if (exp_q.size() == 0) begin
                chk({tag, "_overrun_busy"}, busy, 0);
                done = 1'b1;
            end else if (exp_q[0].err) begin
                chk({tag, "_errwait_shift"}, shift_en, 0);
                chk({tag, "_errwait_blk"}, blk_done, 0);
                if (err) begin
                    chk({tag, "_err_busy"}, busy, 0);
                    chk({tag, "_err_ready"}, in_ready, 0);
                    chk({tag, "_err_pkt"}, pkt_done, 0);
                    done = 1'b1;
                end
            end else begin
                e       = exp_q[0];
                exp_sh  = (e.amt <= avail_m);
                cons    = exp_sh ? e.amt : 0;
                exp_rdy = ((avail_m - cons) <= 32);
                chk({tag, "_shift_en"}, shift_en, exp_sh);
                chk({tag, "_in_ready"}, in_ready, exp_rdy);
                chk({tag, "_refill"}, refill, exp_rdy && in_valid);
                chk({tag, "_blk_done"}, blk_done, exp_sh && e.last_blk);
                chk({tag, "_pkt_early"}, pkt_done, 0);
                chk({tag, "_busy"}, busy, 1);
                if (exp_sh) begin
                    chk({tag, "_shift_amt"}, shift_amt, e.amt);
                    chk({tag, "_phase"}, phase, e.ph);
                    chk({tag, "_k_out"}, k_out, e.k);
                    void'(exp_q.pop_front());
                    if (e.last_blk) begin
                        in_next  = 1'b1;
                        next_pkt = e.last_pkt;
                    end
                    abort_now = abort_split && (e.ph == 1);
                end else begin
                    stall_cnt++;
                end
                if (exp_rdy && in_valid) begin
                    chk({tag, "_refill_pos"}, refill_pos, 32 - (avail_m - cons));
                    avail_m = avail_m - cons + 32;
                end else begin
                    avail_m = avail_m - cons;
                end
            end
            if (fire && word_q.size() > 0) void'(word_q.pop_front());
            if (abort_now) begin
                reset = 1'b1;
                #1;
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_shift"}, shift_en, 0);
                chk({tag, "_rst_ready"}, in_ready, 0);
                chk({tag, "_rst_phase"}, phase, 0);
                chk({tag, "_rst_k"}, k_out, 0);
                chk({tag, "_rst_pkt"}, pkt_done, 0);
                chk({tag, "_rst_blk"}, blk_done, 0);
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                chk({tag, "_post_rst_busy"}, busy, 0);
                chk({tag, "_post_rst_pkt"}, pkt_done, 0);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        $display("pkt %s j=%0d nblk=%0d cycles=%0d left=%0d", tag, j, nblk, cyc, exp_q.size());
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        start    = 1'b0;
        cfg_j    = 6'd0;
        cfg_nblk = 8'd0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_k", k_out, 0);
        chk("rst_phase", phase, 0);
        chk("rst_strobes", {ldor, refill, shift_en, blk_done, pkt_done}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ID=1, one '1' code, one zero split bit: 0x18000000 then 0x0
        new_pkt(); add_hdr(1); add_fs(0); add_split(0); mark_last(1); pack_words();
        run_pkt("basic", 1, 1, 1, 6, 1'b0);

        new_pkt(); add_hdr(15); pack_words();
        run_pkt("id15", 4, 1, 1, 0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("err_sticky", err, 1);
            chk("err_idle_busy", busy, 0);
            chk("err_blk", blk_done, 0);
            @(posedge clk); #1;
        end

        new_pkt(); add_block(0, 32, 1'b1); mark_last(1); pack_words();
        run_pkt("k0_ones", 32, 1, 1, 0, 1'b0);

        new_pkt(); add_hdr(0);
        for (int s = 0; s < 28; s++) add_fs(0);
        add_err_marker(); pack_words();
        run_pkt("zero64", 32, 1, 1, 0, 1'b0);

        new_pkt(); add_block(0, 32, 1'b1); mark_last(0);
        add_hdr(0);
        for (int s = 0; s < 21; s++) add_fs(0);
        add_fs(4);
        for (int s = 0; s < 10; s++) add_fs(0);
        mark_last(1); pack_words();
        run_pkt("stall", 32, 2, 2, 0, 1'b0);

        new_pkt(); add_block(3, 4, 1'b0); mark_last(1); pack_words();
        run_pkt("abort", 4, 1, 1, 0, 1'b1);

        for (int p = 0; p < 10; p++) begin
            int nb, jj;
            nb = int'($urandom_range(1, 3));
            jj = int'($urandom_range(1, 32));
            new_pkt();
            for (int b = 0; b < nb; b++) begin
                add_block(int'($urandom_range(0, 14)), jj, 1'b0);
                mark_last(b == nb - 1);
            end
            pack_words();
            run_pkt("rand", jj, nb, 0, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
